// File: rtl/int_vector_ctrl.sv
// ----------------------------------------------------------------------------
// int_vector_ctrl
//
// Registered interrupt controller. Request lines are captured into a pending
// register and masked. The lowest-index eligible source wins. It is offered
// to the CPU with a handler vector formed as Base | (index << VEC_SHIFT).
// A request / acknowledge / end-of-interrupt handshake keeps exactly one
// interrupt in service at a time. Requests that arrive during an offer or
// during service stay pending and are arbitrated on the return to idle.
//
// Build option:
//   INT_EDGE_DETECT_EN  defined   -> rising-edge capture, using a per-source
//                                    history register
//                       undefined -> level capture (default)
//
// Parameters:
//   N_SRC      number of interrupt sources (2..32)
//   VEC_W      width of Base and Vector
//   VEC_SHIFT  left shift applied to the source index before the OR
//   IDW        source index width, $clog2(N_SRC) (local)
//
// Ports:
//   CLK       in   rising-edge clock
//   Reset     in   asynchronous active-high reset, clears all state
//   IntReq    in   raw request lines [N_SRC]
//   Mask      in   per-source enable, 1 = enabled [N_SRC]
//   Base      in   handler table base address [VEC_W]
//   Ack       in   CPU accepts the offered interrupt
//   Eoi       in   handler finished
//   IntOut    out  interrupt request to the CPU
//   Vector    out  registered handler address [VEC_W]
//   ActiveId  out  registered index of the offered / in-service source [IDW]
//   Busy      out  an interrupt is in service
// ----------------------------------------------------------------------------
module int_vector_ctrl #(
    parameter  int unsigned N_SRC     = 8,
    parameter  int unsigned VEC_W     = 16,
    parameter  int unsigned VEC_SHIFT = 2,
    localparam int unsigned IDW       = $clog2(N_SRC)
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [N_SRC-1:0] IntReq,
    input  logic [N_SRC-1:0] Mask,
    input  logic [VEC_W-1:0] Base,
    input  logic             Ack,
    input  logic             Eoi,
    output logic             IntOut,
    output logic [VEC_W-1:0] Vector,
    output logic [IDW-1:0]   ActiveId,
    output logic             Busy
);

    // The shifted index is built in a field wide enough to hold every bit.
    // It is then cut back to VEC_W, so index bits above the vector width
    // are discarded.
    localparam int unsigned WIDE_W = VEC_W + IDW + VEC_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_e;

    state_e             state_q, state_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   pend_set;
    logic [N_SRC-1:0]   pend_clr;
    logic [N_SRC-1:0]   elig;
    logic               any_elig;
    logic [IDW-1:0]     win_idx;
    logic [WIDE_W-1:0]  offs_wide;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [IDW-1:0]     id_q, id_d;
    logic               offer_load;
    logic               ack_taken;

    // ------------------------------------------------------------------
    // Capture
    // ------------------------------------------------------------------
`ifdef INT_EDGE_DETECT_EN
    logic [N_SRC-1:0] hist_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= IntReq;
        end
    end

    // Only a 0->1 transition pends, so a line held high raises one interrupt.
    assign pend_set = IntReq & ~hist_q;
`else
    assign pend_set = IntReq;
`endif

    // ------------------------------------------------------------------
    // Pending register: clear on an accepted Ack for the offered source.
    // A set on the same bit wins, so a still-asserted level request
    // re-pends at once.
    // ------------------------------------------------------------------
    assign ack_taken = (state_q == ST_REQ) && Ack;

    always_comb begin
        pend_clr = '0;
        if (ack_taken) begin
            pend_clr[id_q] = 1'b1;
        end
    end

    assign pend_d = (pend_q & ~pend_clr) | pend_set;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: lowest eligible index wins. The loop scans from the top
    // down, so the last hit, which is the lowest index, takes priority.
    // ------------------------------------------------------------------
    assign elig     = pend_q & Mask;
    assign any_elig = |elig;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = N_SRC; i > 0; i--) begin
            if (elig[i-1]) begin
                win_idx = IDW'(i - 1);
            end
        end
    end

    assign offs_wide = WIDE_W'(win_idx) << VEC_SHIFT;

    // ------------------------------------------------------------------
    // Offer registers: loaded only when leaving IDLE. They stay frozen
    // through REQ and SERVICE, which keeps the offer committed even if
    // Mask or IntReq change.
    // ------------------------------------------------------------------
    assign offer_load = (state_q == ST_IDLE) && any_elig;

    always_comb begin
        vec_d = vec_q;
        id_d  = id_q;
        if (offer_load) begin
            vec_d = Base | offs_wide[VEC_W-1:0];
            id_d  = win_idx;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            vec_q <= '0;
            id_q  <= '0;
        end else begin
            vec_q <= vec_d;
            id_q  <= id_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM: next state. Ack is honoured only in REQ, and Eoi only
    // in SERVICE. With both inputs high in REQ, Ack wins.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_elig) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (Ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (Eoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM: outputs. These are decoded from the state register
    // alone, so no input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        IntOut = 1'b0;
        Busy   = 1'b0;
        unique case (state_q)
            ST_REQ:     IntOut = 1'b1;
            ST_SERVICE: Busy   = 1'b1;
            default: begin
                IntOut = 1'b0;
                Busy   = 1'b0;
            end
        endcase
    end

    assign Vector   = vec_q;
    assign ActiveId = id_q;

endmodule

// File: tb/tb_int_vector_ctrl.sv
`timescale 1ns/1ps
module tb_int_vector_ctrl;

`ifdef INT_EDGE_DETECT_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif
    localparam int N = 8;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [7:0]  req, mask;
    logic [15:0] base;
    logic        ack, eoi;
    logic        int_out, busy;
    logic [15:0] vector;
    logic [2:0]  active_id;

    logic [31:0] req2, mask2;
    logic [7:0]  base2;
    logic        ack2, eoi2;
    logic        int_out2, busy2;
    logic [7:0]  vector2;
    logic [4:0]  active_id2;

    int total = 0;
    int bad   = 0;

    // Reference model: pending set, offer/service flags, committed offer
    bit [7:0] m_pend, m_prev;
    bit       m_offer, m_serve;
    int       m_id, m_vec;

    always #5 CLK = ~CLK;

    int_vector_ctrl #(.N_SRC(8), .VEC_W(16), .VEC_SHIFT(2)) u_dut (
        .CLK(CLK), .Reset(Reset), .IntReq(req), .Mask(mask), .Base(base),
        .Ack(ack), .Eoi(eoi), .IntOut(int_out), .Vector(vector),
        .ActiveId(active_id), .Busy(busy)
    );

    int_vector_ctrl #(.N_SRC(32), .VEC_W(8), .VEC_SHIFT(4)) u_dut_wide (
        .CLK(CLK), .Reset(Reset), .IntReq(req2), .Mask(mask2), .Base(base2),
        .Ack(ack2), .Eoi(eoi2), .IntOut(int_out2), .Vector(vector2),
        .ActiveId(active_id2), .Busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_offer = 1'b0;
        m_serve = 1'b0;
        m_id    = 0;
        m_vec   = 0;
    endtask

    // One rising edge of the reference model, evaluated on pre-edge inputs
    task automatic model_edge();
        bit [7:0] elig, setv, clrv;
        int       lo;
        bit       found;
        if (Reset) begin
            model_reset();
            return;
        end
        elig  = m_pend & mask;
        found = 1'b0;
        lo    = 0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && !found) begin
                found = 1'b1;
                lo    = i;
            end
        end
        setv = EDGE_MODE ? (req & ~m_prev) : req;
        clrv = '0;
        if (m_offer && ack) clrv[m_id] = 1'b1;
        m_pend = (m_pend & ~clrv) | setv;
        m_prev = req;
        if (m_offer) begin
            if (ack) begin
                m_offer = 1'b0;
                m_serve = 1'b1;
            end
        end else if (m_serve) begin
            if (eoi) m_serve = 1'b0;
        end else if (found) begin
            m_offer = 1'b1;
            m_id    = lo;
            m_vec   = (int'(base) | (lo * 4)) & 32'hFFFF;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        chk("m_intout", int_out, m_offer);
        chk("m_busy", busy, m_serve);
        chk("m_vector", vector, m_vec);
        chk("m_id", active_id, m_id);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    int  rises;
    bit  prev_io;

    initial begin
        Reset = 1'b1;
        req = '0; mask = 8'hFF; base = '0; ack = 1'b0; eoi = 1'b0;
        req2 = '0; mask2 = '0; base2 = '0; ack2 = 1'b0; eoi2 = 1'b0;
        model_reset();

        // Reset state
        step();
        chk("rst_intout", int_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vector", vector, 0);
        chk("rst_id", active_id, 0);
        chk("rst_wide_vec", vector2, 0);
        Reset = 1'b0;

        // Vector formation and 2-cycle latency
        base = 16'h0100;
        req  = 8'h20;
        step();
        chk("lat_no_req_yet", int_out, 0);
        req = 8'h00;
        step();
        chk("vec_intout", int_out, 1);
        chk("vec_value", vector, 16'h0114);
        chk("vec_id", active_id, 5);

        // Asynchronous reset mid-REQ, checked before any clock edge
        Reset = 1'b1;
        #1;
        chk("arst_intout", int_out, 0);
        chk("arst_vector", vector, 0);
        chk("arst_id", active_id, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        step();
        Reset = 1'b0;

        // Priority and masking
        req = 8'hA0;
        step();
        req = 8'h00;
        step();
        chk("prio_id5", active_id, 5);
        do_reset();
        mask = 8'hDF;
        req  = 8'hA0;
        step();
        req = 8'h00;
        step();
        chk("mask_id7", active_id, 7);
        chk("mask_vec", vector, 16'h011C);
        mask = 8'hFF;

        // Commitment, handshake, no nesting, ignored inputs
        do_reset();
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        chk("commit_id3", active_id, 3);
        mask = 8'hF7;
        step();
        step();
        chk("commit_hold", int_out, 1);
        chk("commit_vec", vector, 16'h010C);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("eoi_in_req_ign", int_out, 1);
        ack = 1'b1;
        eoi = 1'b1;
        step();
        ack = 1'b0;
        eoi = 1'b0;
        chk("ack_busy", busy, 1);
        chk("ack_intout", int_out, 0);
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        chk("nonest_intout", int_out, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ack_in_svc_ign", busy, 1);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("eoi_busy0", busy, 0);
        chk("eoi_intout0", int_out, 0);
        step();
        chk("next_intout", int_out, 1);
        chk("next_id1", active_id, 1);
        chk("next_vec", vector, 16'h0104);
        mask = 8'hFF;
        ack = 1'b1;
        step();
        ack = 1'b0;
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();

        // Capture mode: IntReq[0] held high for 20 cycles, CPU answers promptly
        do_reset();
        req     = 8'h01;
        rises   = 0;
        prev_io = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (int_out && !prev_io) rises++;
            prev_io = int_out;
            ack = int_out;
            eoi = busy;
        end
        chk("capture_mode", EDGE_MODE ? (rises == 1) : (rises >= 2), 1);
        req = 8'h00;
        ack = 1'b0;
        eoi = 1'b0;

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req   = 8'($urandom & $urandom & $urandom);
            mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 15) == 0) base = 16'($urandom);
            ack   = ($urandom_range(0, 2) == 0);
            eoi   = ($urandom_range(0, 2) == 0);
            Reset = ($urandom_range(0, 99) == 0);
            step();
        end
        Reset = 1'b0;
        req = '0; ack = 1'b0; eoi = 1'b0; mask = 8'hFF;

        // Width boundary: source 31, VEC_W 8, VEC_SHIFT 4
        do_reset();
        req2  = 32'h8000_0000;
        mask2 = '1;
        base2 = 8'h0F;
        step();
        chk("wide_latency", int_out2, 0);
        req2 = '0;
        step();
        chk("wide_intout", int_out2, 1);
        chk("wide_vector", vector2, 8'hFF);
        chk("wide_id", active_id2, 31);
        chk("wide_busy", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_vector_ctrl.md
# int_vector_ctrl

- Parametrised, registered interrupt controller for the processor's interrupt path.
- Captures up to N_SRC request lines into a pending register, masks them, and selects the highest-priority source (lowest index).
- Forms the handler vector by ORing a base address with the shifted source index.
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU control unit, so only one interrupt is in service at a time.

## Interface

Parameters:
- N_SRC, 8: number of interrupt sources, 2..32.
- VEC_W, 16: width of Base and Vector.
- VEC_SHIFT, 2: left shift applied to the source index before the OR.
- IDW, $clog2(N_SRC): source index width (localparam).

Ports:
- CLK, input, 1: single clock, rising edge.
- Reset, input, 1: asynchronous, active-high. Clears all state.
- IntReq, input, N_SRC: raw interrupt request lines.
- Mask, input, N_SRC: per-source enable (1 = enabled).
- Base, input, VEC_W: handler table base address.
- Ack, input, 1: CPU accepts the offered interrupt.
- Eoi, input, 1: handler finished (return-from-interrupt).
- IntOut, output, 1: interrupt request to the CPU.
- Vector, output, VEC_W: registered handler address.
- ActiveId, output, IDW: registered index of the offered or in-service source.
- Busy, output, 1: an interrupt is in service.

## Operation

- **Pending register** P[N_SRC-1:0]:
  - Bit i sets per the capture mode (see Configuration).
  - Bit i clears when Ack is accepted for source i.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Selection:** the winner is the lowest index i with P[i] & Mask[i].
- **Vector:** Vector = Base | ({winner, VEC_SHIFT zeros} truncated or zero-extended to VEC_W). Bits above VEC_W are discarded.
- **FSM**, encoded as three states:
  - IDLE: if any P & Mask bit is set, latch the winner into ActiveId/Vector and go to REQ. Otherwise stay.
  - REQ: IntOut = 1; Vector and ActiveId stay frozen. On Ack, clear P[ActiveId] and go to SERVICE.
  - SERVICE: IntOut = 0, Busy = 1. On Eoi, go to IDLE. Busy = 0 from the next cycle.
- **Commitment:** once in REQ, the offer is committed. Deasserting Mask or IntReq for that source does not withdraw it.
- **Ignored inputs:**
  - Ack in IDLE or SERVICE is ignored.
  - Eoi in IDLE or REQ is ignored.
  - Ack and Eoi together in REQ: Ack is taken, Eoi is ignored.
- **No nesting:** requests arriving during REQ or SERVICE accumulate in P and are arbitrated on return to IDLE.

## Timing

- **Reset values:** IntOut = 0, Busy = 0, Vector = 0, ActiveId = 0, P = 0, FSM = IDLE, edge-history register = 0. Reset is honoured mid-handshake: any offer or service in progress is abandoned.
- **Request latency:**
  - IntReq is sampled into P at edge k.
  - The IDLE→REQ transition happens at edge k+1.
  - IntOut = 1 and a valid Vector follow edge k+1.
  - Total: 2 cycles from input to request.
- **Ack:** sampled at edge m → IntOut = 0 and Busy = 1 after edge m. P bit cleared at m.
- **Eoi:** sampled at edge n → IDLE after n. The next REQ is earliest after edge n+1.
- **Outputs:** all registered. No combinational path from inputs to outputs.

## Configuration

- **INT_EDGE_DETECT_EN defined:** edge-triggered capture.
  - A per-source history register holds IntReq from the previous cycle.
  - P[i] sets on a 0→1 transition of IntReq[i].
  - A held-high line raises exactly one interrupt.
- **INT_EDGE_DETECT_EN undefined:** level-sensitive capture.
  - P[i] sets on every cycle IntReq[i] = 1.
  - A still-high line re-pends immediately after its Ack clear (set wins).
  - No history register is built.

## Test plan

- **Reset and vector formation:** assert Reset mid-REQ → all outputs 0 next cycle, no CLK needed. Release Reset, set Base = 16'h0100 and pulse IntReq[5] → after 2 edges, IntOut = 1, Vector = 16'h0114, ActiveId = 5.
- **Priority and masking:** IntReq = 8'b1010_0000 with Mask = 8'hFF → ActiveId = 5. Repeat with Mask = 8'h DF → ActiveId = 7.
- **Full handshake:** Ack while IntOut = 1 → IntOut = 0, Busy = 1. Raise IntReq[1] during SERVICE → no IntOut. Eoi → Busy = 0, then IntOut = 1 with ActiveId = 1.
- **Commitment:** Mask[3] drops while REQ for source 3 → IntOut stays 1 and Vector is unchanged until Ack. Ack outside REQ → no state change.
- **Capture mode:** IntReq[0] held high for 20 cycles across two Ack/Eoi rounds.
  - Edge mode: exactly one service.
  - Level mode: a second REQ follows the first Eoi.
- **Width boundary:** N_SRC = 32, VEC_W = 8, VEC_SHIFT = 4, Base = 8'h0F, source 31 → Vector = 8'hFF (index bits above bit 7 dropped).
